apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  APB initiator driving the I2C controller's APB register slave (command/transmit/status/receive/address map).
//  Accepts one host command at a time over a valid/ready handshake and runs the APB SETUP/ACCESS sequence.
//  Waits for PREADY, then returns read data and status on a one-cycle response strobe.
//  Sits between the host sequencer (test controller or CPU shim) and the APB bus of the I2C subsystem.
// PARAMETERS
//  ADDRESSWIDTH    8   width of PADDR and cmd_addr
//  DATAWIDTH       8   width of PWDATA/PRDATA and command/response data
//  TIMEOUT_CYCLES  16  max ACCESS-phase cycles with PREADY low (used only with APB_TIMEOUT_EN)
// PORTS
//  PCLK        in   1             APB clock; the single clock of the block
//  PRESET      in   1             reset; synchronous to PCLK, active-high
//  cmd_valid   in   1             host presents a command
//  cmd_ready   out  1             master accepts; transfer when cmd_valid & cmd_ready
//  cmd_write   in   1             1 = APB write, 0 = APB read
//  cmd_addr    in   ADDRESSWIDTH  target register address
//  cmd_wdata   in   DATAWIDTH     write data (ignored for reads)
//  rsp_valid   out  1             one-cycle strobe: transfer complete
//  rsp_rdata   out  DATAWIDTH     PRDATA captured on read completion; held until the next read completes
//  rsp_err     out  1             valid with rsp_valid; 1 = timeout abort (always 0 without macro)
//  PADDR       out  ADDRESSWIDTH  APB address
//  PWDATA      out  DATAWIDTH     APB write data
//  PWRITE      out  1             APB direction
//  PSELx       out  1             APB slave select
//  PENABLE     out  1             APB access phase
//  PRDATA      in   DATAWIDTH     APB read data
//  PREADY      in   1             APB slave ready
// BEHAVIOUR
//  Reset (PRESET=1 at a PCLK edge): state=IDLE.
//   PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; cmd_ready=1 the cycle after.
//  FSM states:
//   IDLE:   cmd_ready=1. On cmd_valid, register addr/wdata/write onto PADDR/PWDATA/PWRITE, PSELx<=1, go SETUP.
//   SETUP:  exactly one cycle; PENABLE<=1, go ACCESS. cmd_ready=0.
//   ACCESS: hold PADDR/PWDATA/PWRITE/PSELx/PENABLE stable; cmd_ready=0.
//    On PREADY=1: PENABLE<=0, rsp_valid<=1 next cycle; if !PWRITE, rsp_rdata<=PRDATA.
//     If cmd_valid is also high the same cycle, no back-to-back: return to IDLE; new command accepted in IDLE.
//     Otherwise PSELx<=0, go IDLE.
//  Bus pins change only on IDLE->SETUP and on ACCESS exit; never mid-ACCESS.
//  Minimum transfer: 3 cycles (IDLE accept, SETUP, ACCESS with PREADY=1); rsp_valid 1 cycle after ACCESS completes.
//  Each wait cycle (PREADY=0) adds one cycle. Without the macro, waits are unbounded.
//  cmd_* sampled only on the accept cycle; later changes are ignored.
//  Reset mid-transfer: bus returns to idle on the same edge. No rsp_valid is issued for the aborted command.
//  rsp_valid never asserts two cycles in a row.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   Wait counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
//   When it reaches TIMEOUT_CYCLES: drop PSELx/PENABLE, pulse rsp_valid with rsp_err=1, leave rsp_rdata unchanged, go IDLE.
//   A PREADY=1 arriving on the same cycle as expiry wins: normal completion, rsp_err=0.
//  APB_TIMEOUT_EN undefined: no counter, rsp_err tied 0, TIMEOUT_CYCLES unused.
// STRUCTURE
//  Shared package apb_pkg:
//   state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
//   register map constants: REG_COMMAND=2, REG_STATUS=3, REG_TRANSMIT=4, REG_RECEIVE=5, REG_ADDRESS=6
//   the same package serves the slave side.
//  One sub-module, apb_wait_timer: counter + expiry flag. Instantiated only under APB_TIMEOUT_EN.
//  FSM and datapath registers stay in apb_master.
// TESTING
//  1. Write 0xA5 to addr 4, PREADY tied 1:
//     PSELx high 2 cycles, PENABLE high 1 cycle, PWDATA=0xA5 stable, rsp_valid 1 cycle later, rsp_err=0.
//  2. Read addr 3, PRDATA=0x3C, PREADY low 3 ACCESS cycles:
//     ACCESS lasts 4 cycles, bus stable throughout, rsp_rdata=0x3C with rsp_valid.
//  3. cmd_valid held high across two writes (addr 2 then addr 6):
//     second accepted only in IDLE after the first completes; PSELx deasserts 1 cycle between transfers.
//  4. PRESET asserted during ACCESS:
//     next edge gives PSELx=PENABLE=0, rsp_valid=0, state IDLE; new command then completes normally.
//  5. APB_TIMEOUT_EN, PREADY stuck 0, TIMEOUT_CYCLES=16:
//     after 16 wait cycles rsp_valid=1, rsp_err=1, bus idle; PREADY=1 on cycle 16 gives rsp_err=0.
//  6. Read of addr 5 after read of addr 3:
//     rsp_rdata updates only at each read completion; an intervening write leaves it unchanged.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//  Shared definitions for the APB initiator and the I2C controller's APB
//  register slave: the transfer state encoding and the register address map.
//  No ports (package).
// ---------------------------------------------------------------------------
package apb_pkg;

   // Transfer phases of the APB initiator; the encoding is shared with the
   // slave side so both ends can be probed with the same decode.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

   // I2C controller register map as seen on PADDR.
   localparam logic [7:0] REG_COMMAND  = 8'd2;
   localparam logic [7:0] REG_STATUS   = 8'd3;
   localparam logic [7:0] REG_TRANSMIT = 8'd4;
   localparam logic [7:0] REG_RECEIVE  = 8'd5;
   localparam logic [7:0] REG_ADDRESS  = 8'd6;

endpackage

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer
//  Counts ACCESS-phase wait cycles (PREADY low) and flags the cycle on which
//  the LIMIT-th wait would be spent, so the master can abort the transfer on
//  that same edge.
//  Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   clear    in  restart the count (driven while the master is in SETUP)
//   tick     in  one wait cycle is being spent this cycle
//   expired  out this tick is the LIMIT-th wait cycle
// ---------------------------------------------------------------------------
module apb_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   // The counter holds the number of wait cycles already completed; it
   // saturates at LIMIT so it can never wrap if the master lingers.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick && (count != CW'(LIMIT))) begin
         count <= count + CW'(1);
      end
   end

   // Expiry is combinational so the abort lands on the edge that ends the
   // LIMIT-th wait cycle rather than one cycle later.
   assign expired = tick && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//  APB initiator for the I2C subsystem register slave. Accepts one host
//  command at a time over cmd_valid/cmd_ready, runs SETUP then ACCESS on the
//  APB bus, waits for PREADY and reports completion on a one-cycle rsp_valid.
//  Optional feature macro: APB_TIMEOUT_EN bounds the ACCESS wait to
//  TIMEOUT_CYCLES and aborts with rsp_err=1 when it expires.
//  Ports:
//   PCLK, PRESET              clock, synchronous active-high reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_write/addr/wdata      command fields, sampled on the accept cycle
//   rsp_valid/rdata/err       completion strobe, read data, timeout flag
//   PADDR/PWDATA/PWRITE       APB address, write data, direction
//   PSELx/PENABLE             APB select and access phase
//   PRDATA/PREADY             APB read data and slave ready
// ---------------------------------------------------------------------------
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDRESSWIDTH   = 8,
   parameter int DATAWIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDRESSWIDTH-1:0] cmd_addr,
   input  logic [DATAWIDTH-1:0]    cmd_wdata,
   output logic                    rsp_valid,
   output logic [DATAWIDTH-1:0]    rsp_rdata,
   output logic                    rsp_err,
   output logic [ADDRESSWIDTH-1:0] PADDR,
   output logic [DATAWIDTH-1:0]    PWDATA,
   output logic                    PWRITE,
   output logic                    PSELx,
   output logic                    PENABLE,
   input  logic [DATAWIDTH-1:0]    PRDATA,
   input  logic                    PREADY
);

   apb_state_t state;
   logic       timeout_hit;

`ifdef APB_TIMEOUT_EN
   // The wait budget restarts in SETUP so every transfer gets the full
   // TIMEOUT_CYCLES of PREADY-low cycles in ACCESS.
   apb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (PCLK),
      .reset   (PRESET),
      .clear   (state == ST_SETUP),
      .tick    ((state == ST_ACCESS) && !PREADY),
      .expired (timeout_hit)
   );
`else
   // Without the timeout feature a slave may stall forever; the parameter
   // is kept on the interface so both builds instantiate identically.
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
   assign timeout_hit        = 1'b0;
`endif

   // Single-process FSM with every output registered. Bus pins only move on
   // the accept edge (IDLE->SETUP) and on ACCESS exit. A command presented
   // during the completing cycle is not taken back-to-back: the FSM always
   // spends one IDLE cycle with PSELx low before accepting the next one.
   // PREADY is checked before the timeout so a late ready still completes
   // normally on the expiry cycle.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b1;
         PSELx     <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  PADDR     <= cmd_addr;
                  PWDATA    <= cmd_wdata;
                  PWRITE    <= cmd_write;
                  PSELx     <= 1'b1;
                  cmd_ready <= 1'b0;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  PSELx     <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
                  if (!PWRITE) begin
                     rsp_rdata <= PRDATA;
                  end
               end else if (timeout_hit) begin
                  PSELx     <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               PSELx     <= 1'b0;
               PENABLE   <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//  Self-checking bench for apb_master. A cycle-by-cycle vector table drives
//  the host and APB slave inputs and lists the registered outputs expected
//  after each PCLK edge; hand-written sequences cover a held cmd_valid across
//  two transfers and, when APB_TIMEOUT_EN is defined, the wait timeout.
// ---------------------------------------------------------------------------
module tb_apb_master;
   import apb_pkg::*;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic       PWRITE;
   logic       PSELx;
   logic       PENABLE;
   logic [7:0] PRDATA;
   logic       PREADY;

   int checks   = 0;
   int failures = 0;
   int back2back = 0;
   logic prev_rv = 1'b0;

   apb_master #(
      .ADDRESSWIDTH   (8),
      .DATAWIDTH      (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PWRITE    (PWRITE),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY)
   );

   // Free-running 100 MHz APB clock.
   always #5 PCLK = ~PCLK;

   // Watches for rsp_valid high on two consecutive cycles anywhere in the run.
   always @(negedge PCLK) begin
      if (rsp_valid && prev_rv) back2back++;
      prev_rv = rsp_valid;
   end

   // Hard stop in case some wait is ever left unbounded.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   typedef struct {
      string      name;
      logic       rst;
      logic       valid;
      logic       write;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       ready;
      logic [7:0] prdata;
      logic [29:0] exp_out;
   } vec_t;

   // Expected bundle order: cmd_ready, PSELx, PENABLE, PWRITE, PADDR,
   // PWDATA, rsp_valid, rsp_rdata, rsp_err.
   function automatic logic [29:0] E(input logic rdy, sel, en, wr,
                                     input logic [7:0] a, wd,
                                     input logic rv,
                                     input logic [7:0] rd,
                                     input logic err);
      return {rdy, sel, en, wr, a, wd, rv, rd, err};
   endfunction

   function automatic vec_t mk(input string nm, input logic rst, valid, write,
                               input logic [7:0] addr, wdata,
                               input logic ready,
                               input logic [7:0] prdata,
                               input logic [29:0] e);
      vec_t v;
      v.name = nm; v.rst = rst; v.valid = valid; v.write = write;
      v.addr = addr; v.wdata = wdata; v.ready = ready; v.prdata = prdata;
      v.exp_out = e;
      return v;
   endfunction

   function automatic logic [29:0] observed();
      return {cmd_ready, PSELx, PENABLE, PWRITE, PADDR, PWDATA,
              rsp_valid, rsp_rdata, rsp_err};
   endfunction

   // Drive one cycle of inputs, then sample just after the next rising edge.
   task automatic applyStimulus(input vec_t v);
      PRESET    = v.rst;
      cmd_valid = v.valid;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      PREADY    = v.ready;
      PRDATA    = v.prdata;
      @(posedge PCLK);
      #1;
   endtask

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", nm, act, req);
      end
   endtask

   task automatic stepCycle();
      @(posedge PCLK);
      #1;
   endtask

   // Counts edges until rsp_valid is seen, giving up after max_cycles.
   task automatic waitResponse(input int max_cycles, output int n);
      n = 0;
      do begin
         stepCycle();
         n++;
      end while (!rsp_valid && n < max_cycles);
      if (!rsp_valid) n = max_cycles + 1;
   endtask

   vec_t vecs[$];
   int   n;

   initial begin
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; PREADY = 1'b1; PRDATA = '0;

      //            name                  rst v  w  addr          wdata  rdy prdata   rdy sel en wr addr          wd     rv rd     err
      vecs.push_back(mk("reset0",           1, 0, 0, 8'h00,        8'h00, 1, 8'h00, E(1, 0, 0, 0, 8'h00,        8'h00, 0, 8'h00, 0)));
      vecs.push_back(mk("reset_with_cmd",   1, 1, 1, 8'h44,        8'h55, 1, 8'h00, E(1, 0, 0, 0, 8'h00,        8'h00, 0, 8'h00, 0)));
      vecs.push_back(mk("wr_accept",        0, 1, 1, REG_TRANSMIT, 8'hA5, 1, 8'h00, E(0, 1, 0, 1, REG_TRANSMIT, 8'hA5, 0, 8'h00, 0)));
      vecs.push_back(mk("wr_setup",         0, 0, 0, 8'h00,        8'h00, 1, 8'h00, E(0, 1, 1, 1, REG_TRANSMIT, 8'hA5, 0, 8'h00, 0)));
      vecs.push_back(mk("wr_done",          0, 0, 0, 8'h00,        8'h00, 1, 8'h00, E(1, 0, 0, 1, REG_TRANSMIT, 8'hA5, 1, 8'h00, 0)));
      vecs.push_back(mk("wr_idle",          0, 0, 0, 8'h00,        8'h00, 1, 8'h00, E(1, 0, 0, 1, REG_TRANSMIT, 8'hA5, 0, 8'h00, 0)));
      vecs.push_back(mk("rd_accept",        0, 1, 0, REG_STATUS,   8'h77, 1, 8'h00, E(0, 1, 0, 0, REG_STATUS,   8'h77, 0, 8'h00, 0)));
      vecs.push_back(mk("rd_setup_newcmd",  0, 1, 1, 8'h05,        8'hEE, 0, 8'h00, E(0, 1, 1, 0, REG_STATUS,   8'h77, 0, 8'h00, 0)));
      vecs.push_back(mk("rd_wait1",         0, 1, 1, 8'h05,        8'hEE, 0, 8'h3C, E(0, 1, 1, 0, REG_STATUS,   8'h77, 0, 8'h00, 0)));
      vecs.push_back(mk("rd_wait2",         0, 0, 0, 8'h00,        8'h00, 0, 8'h3C, E(0, 1, 1, 0, REG_STATUS,   8'h77, 0, 8'h00, 0)));
      vecs.push_back(mk("rd_wait3",         0, 0, 0, 8'h00,        8'h00, 0, 8'h3C, E(0, 1, 1, 0, REG_STATUS,   8'h77, 0, 8'h00, 0)));
      vecs.push_back(mk("rd_done",          0, 0, 0, 8'h00,        8'h00, 1, 8'h3C, E(1, 0, 0, 0, REG_STATUS,   8'h77, 1, 8'h3C, 0)));
      vecs.push_back(mk("rd_hold",          0, 0, 0, 8'h00,        8'h00, 1, 8'hFF, E(1, 0, 0, 0, REG_STATUS,   8'h77, 0, 8'h3C, 0)));
      vecs.push_back(mk("rd5_accept",       0, 1, 0, REG_RECEIVE,  8'h00, 1, 8'hFF, E(0, 1, 0, 0, REG_RECEIVE,  8'h00, 0, 8'h3C, 0)));
      vecs.push_back(mk("rd5_setup",        0, 0, 0, 8'h00,        8'h00, 1, 8'hFF, E(0, 1, 1, 0, REG_RECEIVE,  8'h00, 0, 8'h3C, 0)));
      vecs.push_back(mk("rd5_done",         0, 0, 0, 8'h00,        8'h00, 1, 8'h5A, E(1, 0, 0, 0, REG_RECEIVE,  8'h00, 1, 8'h5A, 0)));
      vecs.push_back(mk("wr2_accept",       0, 1, 1, REG_COMMAND,  8'h11, 1, 8'h00, E(0, 1, 0, 1, REG_COMMAND,  8'h11, 0, 8'h5A, 0)));
      vecs.push_back(mk("wr2_setup",        0, 0, 0, 8'h00,        8'h00, 1, 8'hEE, E(0, 1, 1, 1, REG_COMMAND,  8'h11, 0, 8'h5A, 0)));
      vecs.push_back(mk("wr2_keeps_rdata",  0, 0, 0, 8'h00,        8'h00, 1, 8'hEE, E(1, 0, 0, 1, REG_COMMAND,  8'h11, 1, 8'h5A, 0)));
      vecs.push_back(mk("wr6_accept",       0, 1, 1, REG_ADDRESS,  8'h42, 0, 8'h00, E(0, 1, 0, 1, REG_ADDRESS,  8'h42, 0, 8'h5A, 0)));
      vecs.push_back(mk("wr6_setup",        0, 0, 0, 8'h00,        8'h00, 0, 8'h00, E(0, 1, 1, 1, REG_ADDRESS,  8'h42, 0, 8'h5A, 0)));
      vecs.push_back(mk("wr6_wait",         0, 0, 0, 8'h00,        8'h00, 0, 8'h00, E(0, 1, 1, 1, REG_ADDRESS,  8'h42, 0, 8'h5A, 0)));
      vecs.push_back(mk("reset_mid_access", 1, 0, 0, 8'h00,        8'h00, 0, 8'h00, E(1, 0, 0, 0, 8'h00,        8'h00, 0, 8'h00, 0)));
      vecs.push_back(mk("post_reset_idle",  0, 0, 0, 8'h00,        8'h00, 1, 8'h00, E(1, 0, 0, 0, 8'h00,        8'h00, 0, 8'h00, 0)));
      vecs.push_back(mk("rd4_accept",       0, 1, 0, REG_TRANSMIT, 8'h00, 1, 8'h00, E(0, 1, 0, 0, REG_TRANSMIT, 8'h00, 0, 8'h00, 0)));
      vecs.push_back(mk("rd4_setup",        0, 0, 0, 8'h00,        8'h00, 1, 8'h00, E(0, 1, 1, 0, REG_TRANSMIT, 8'h00, 0, 8'h00, 0)));
      vecs.push_back(mk("rd4_done",         0, 0, 0, 8'h00,        8'h00, 1, 8'h99, E(1, 0, 0, 0, REG_TRANSMIT, 8'h00, 1, 8'h99, 0)));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, 32'(observed()), 32'(vecs[i].exp_out));
      end

      // cmd_valid held high across two writes: the second is taken only
      // after one IDLE cycle with PSELx low.
      PRESET = 1'b0; PREADY = 1'b1; PRDATA = 8'h00;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_COMMAND; cmd_wdata = 8'h10;
      stepCycle();
      checkOutput("b2b_first_sel", {31'd0, PSELx}, 32'd1);
      waitResponse(10, n);
      checkOutput("b2b_first_latency", 32'(n), 32'd2);
      checkOutput("b2b_gap", {28'd0, PSELx, cmd_ready, rsp_err, PENABLE}, {28'd0, 4'b0100});
      checkOutput("b2b_first_addr", {24'd0, PADDR}, {24'd0, REG_COMMAND});
      cmd_addr = REG_ADDRESS; cmd_wdata = 8'h20;
      stepCycle();
      checkOutput("b2b_second_accept", {14'd0, PSELx, rsp_valid, PADDR, PWDATA}, {14'd0, 1'b1, 1'b0, REG_ADDRESS, 8'h20});
      cmd_valid = 1'b0;
      waitResponse(10, n);
      checkOutput("b2b_second_latency", 32'(n), 32'd2);
      checkOutput("b2b_second_done", {15'd0, PSELx, rsp_rdata, PWDATA}, {15'd0, 1'b0, 8'h99, 8'h20});
      stepCycle();

`ifdef APB_TIMEOUT_EN
      // PREADY stuck low: abort after the 16th wait cycle, rdata untouched.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_STATUS; PREADY = 1'b0; PRDATA = 8'hC3;
      stepCycle();
      cmd_valid = 1'b0;
      waitResponse(40, n);
      checkOutput("to_latency", 32'(n), 32'd17);
      checkOutput("to_abort", {20'd0, rsp_err, PSELx, PENABLE, rsp_valid, rsp_rdata}, {20'd0, 4'b1001, 8'h99});
      // PREADY rising on the 16th ACCESS cycle still completes normally.
      stepCycle();
      cmd_valid = 1'b1;
      stepCycle();
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) stepCycle();
      checkOutput("to_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
      PREADY = 1'b1; PRDATA = 8'h61;
      stepCycle();
      checkOutput("to_ready_wins", {21'd0, rsp_valid, rsp_err, PSELx, rsp_rdata}, {21'd0, 3'b100, 8'h61});
      stepCycle();
`endif

      checkOutput("rsp_valid_single_cycle", 32'(back2back), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
